// File: rtl/riscv_debug_csr_master_if.sv
// Debug request/response and CSR-port bundle for riscv_debug_csr_master.
// The master modport is the block's view; the slave modport is the debug unit plus core side.
interface riscv_debug_csr_master_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  // debug unit side
  logic              dbg_req_i;
  logic              dbg_gnt_o;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [OP_W-1:0]   dbg_op_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_halt_i;
  logic              dbg_rvalid_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              dbg_err_o;

  // core controller / CSR file side
  logic              dbg_stall_o;
  logic              core_halted_i;
  logic              csr_sel_o;
  logic              csr_access_o;
  logic [ADDR_W-1:0] csr_addr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic [OP_W-1:0]   csr_op_o;
  logic [DATA_W-1:0] csr_rdata_i;

  modport master (
    input  dbg_req_i, dbg_addr_i, dbg_op_i, dbg_wdata_i, dbg_halt_i,
    input  core_halted_i, csr_rdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    output dbg_stall_o, csr_sel_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o
  );

  modport slave (
    output dbg_req_i, dbg_addr_i, dbg_op_i, dbg_wdata_i, dbg_halt_i,
    output core_halted_i, csr_rdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o,
    input  dbg_stall_o, csr_sel_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o
  );
endinterface

// File: rtl/riscv_debug_csr_master.sv
// Debug-side CSR initiator: stalls and drains the core, performs one CSR access in place
// of the ID stage, and returns the pre-operation CSR value (or an error on halt timeout).
module riscv_debug_csr_master #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_debug_csr_master_if.master      bus
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HALT_WAIT = 2'd1,
    S_ACCESS    = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [OP_W-1:0]   op_q,         op_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;

  logic              stall_q,      stall_d;
  logic              sel_q,        sel_d;
  logic              access_q,     access_d;
  logic [ADDR_W-1:0] csr_addr_q,   csr_addr_d;
  logic [OP_W-1:0]   csr_op_q,     csr_op_d;
  logic [DATA_W-1:0] csr_wdata_q,  csr_wdata_d;
  logic              rvalid_q,     rvalid_d;
  logic [DATA_W-1:0] rdata_q,      rdata_d;
  logic              err_q,        err_d;
  logic              gnt_c;

  // Next-state, request capture and halt-wait timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    gnt_c   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        gnt_c = bus.dbg_req_i;
        if (bus.dbg_req_i) begin
          addr_d  = bus.dbg_addr_i;
          op_d    = bus.dbg_op_i;
          wdata_d = bus.dbg_wdata_i;
          cnt_d   = '0;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        // A halt arriving on the last allowed cycle still wins over the timeout.
        if (bus.core_halted_i) begin
          state_d = S_ACCESS;
        end else begin
          if (cnt_q < CNT_W'(HALT_TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q == CNT_W'(HALT_TIMEOUT - 1)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        rdata_d = bus.csr_rdata_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered
  always_comb begin
    stall_d     = (state_d != S_IDLE) || bus.dbg_halt_i;
    sel_d       = (state_d == S_ACCESS);
    access_d    = (state_d == S_ACCESS);
    csr_addr_d  = (state_d == S_ACCESS) ? addr_q  : '0;
    csr_op_d    = (state_d == S_ACCESS) ? op_q    : '0;
    csr_wdata_d = (state_d == S_ACCESS) ? wdata_q : '0;
    rvalid_d    = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      stall_q     <= 1'b0;
      sel_q       <= 1'b0;
      access_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_op_q    <= '0;
      csr_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      stall_q     <= stall_d;
      sel_q       <= sel_d;
      access_q    <= access_d;
      csr_addr_q  <= csr_addr_d;
      csr_op_q    <= csr_op_d;
      csr_wdata_q <= csr_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.dbg_gnt_o    = gnt_c;
  assign bus.dbg_stall_o  = stall_q;
  assign bus.csr_sel_o    = sel_q;
  assign bus.csr_access_o = access_q;
  assign bus.csr_addr_o   = csr_addr_q;
  assign bus.csr_op_o     = csr_op_q;
  assign bus.csr_wdata_o  = csr_wdata_q;
  assign bus.dbg_rvalid_o = rvalid_q;
  assign bus.dbg_rdata_o  = rdata_q;
  assign bus.dbg_err_o    = err_q;

endmodule

// File: tb/tb_riscv_debug_csr_master.sv
// Bench for riscv_debug_csr_master: bench-side CSR file driven by the DUT's CSR port,
// checked against a request-level reference model of the CSR contents and response timing.
module tb_riscv_debug_csr_master;
  localparam int unsigned HT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_debug_csr_master_if bus ();

  riscv_debug_csr_master #(.HALT_TIMEOUT(HT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Core-side CSR file: reads are combinational pre-op, updates land at the access edge
  logic [31:0] csr_file [4096];
  logic [31:0] ref_mem  [4096];

  assign bus.csr_rdata_i = csr_file[bus.csr_addr_o];

  always @(posedge clk) begin
    if (bus.csr_access_o) begin
      case (bus.csr_op_o)
        2'b01:   csr_file[bus.csr_addr_o] <= bus.csr_wdata_o;
        2'b10:   csr_file[bus.csr_addr_o] <= csr_file[bus.csr_addr_o] | bus.csr_wdata_o;
        2'b11:   csr_file[bus.csr_addr_o] <= csr_file[bus.csr_addr_o] & ~bus.csr_wdata_o;
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] op,
                                           input logic [31:0] wd);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  // One request; hdelay = cycles after the grant cycle at which core_halted_i rises.
  // Called at a negedge; returns in the first IDLE cycle after the response.
  task automatic txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input int hdelay, input bit hold_req, output logic [31:0] rd_out);
    int c, w, acc_cnt, acc_cyc, rv_cnt, rv_cyc, exp_acc, exp_rv;
    bit exp_err, done, stall_bad, gnt_bad, quiet_bad;
    logic [31:0] exp_rd, rd;
    logic er;

    exp_err = (hdelay > int'(HT));
    exp_acc = exp_err ? -1 : hdelay + 1;
    exp_rv  = exp_err ? int'(HT) + 1 : hdelay + 2;
    exp_rd  = exp_err ? 32'h0 : ref_mem[a];
    if (!exp_err) ref_mem[a] = apply_op(ref_mem[a], op, wd);

    bus.dbg_req_i     = 1'b1;
    bus.dbg_addr_i    = a;
    bus.dbg_op_i      = op;
    bus.dbg_wdata_i   = wd;
    bus.core_halted_i = 1'b0;
    #1;
    w = 0;
    while (bus.dbg_gnt_o !== 1'b1 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk("gnt_seen", 32'(bus.dbg_gnt_o), 32'h1);

    acc_cnt = 0; acc_cyc = -1; rv_cnt = 0; rv_cyc = -1; rd = '0; er = 1'b0;
    done = 0; stall_bad = 0; gnt_bad = 0; quiet_bad = 0; c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (!hold_req) bus.dbg_req_i = 1'b0;
      bus.core_halted_i = (c >= hdelay);
      #1;
      if (rv_cnt > 0 && c == rv_cyc + 1) begin
        chk("stall_after_resp", 32'(bus.dbg_stall_o), 32'(bus.dbg_halt_i));
        chk("gnt_after_resp", 32'(bus.dbg_gnt_o), 32'(hold_req));
        done = 1;
      end else begin
        if (bus.dbg_stall_o !== 1'b1) stall_bad = 1;
        if (bus.dbg_gnt_o !== 1'b0) gnt_bad = 1;
        if (bus.csr_access_o === 1'b1) begin
          acc_cnt++; acc_cyc = c;
          chk("acc_sel", 32'(bus.csr_sel_o), 32'h1);
          chk("acc_addr", 32'(bus.csr_addr_o), 32'(a));
          chk("acc_op", 32'(bus.csr_op_o), 32'(op));
          chk("acc_wdata", bus.csr_wdata_o, wd);
        end else if (bus.csr_sel_o !== 1'b0 || bus.csr_addr_o !== '0 ||
                     bus.csr_op_o !== '0 || bus.csr_wdata_o !== '0) begin
          quiet_bad = 1;
        end
        if (bus.dbg_rvalid_o === 1'b1) begin
          rv_cnt++; rv_cyc = c; rd = bus.dbg_rdata_o; er = bus.dbg_err_o;
        end else if (bus.dbg_rdata_o !== '0 || bus.dbg_err_o !== 1'b0) begin
          quiet_bad = 1;
        end
      end
    end
    chk("resp_done", 32'(done), 32'h1);
    chk("acc_count", 32'(acc_cnt), exp_err ? 32'h0 : 32'h1);
    chk("acc_cycle", 32'(acc_cyc), 32'(exp_acc));
    chk("rv_count", 32'(rv_cnt), 32'h1);
    chk("rv_cycle", 32'(rv_cyc), 32'(exp_rv));
    chk("rdata", rd, exp_rd);
    chk("err", 32'(er), 32'(exp_err));
    chk("stall_held", 32'(stall_bad), 32'h0);
    chk("gnt_busy", 32'(gnt_bad), 32'h0);
    chk("idle_outputs_zero", 32'(quiet_bad), 32'h0);
    rd_out = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old_mepc, v;
    logic [11:0] a;
    int bad;

    bus.dbg_req_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_op_i = '0; bus.dbg_wdata_i = '0;
    bus.dbg_halt_i = 1'b0; bus.core_halted_i = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      csr_file[i] <= v;
      ref_mem[i] = v;
    end
    old_mepc = $urandom;
    csr_file[12'h300] <= 32'h7;        ref_mem[12'h300] = 32'h7;
    csr_file[12'h341] <= old_mepc;     ref_mem[12'h341] = old_mepc;
    csr_file[12'h7A0] <= 32'h4;        ref_mem[12'h7A0] = 32'h4;

    // Reset state
    #1;
    chk("rst_outputs", {bus.dbg_gnt_o, bus.dbg_rvalid_o, bus.dbg_err_o, bus.dbg_stall_o,
                        bus.csr_sel_o, bus.csr_access_o, bus.csr_op_o}, 32'h0);
    chk("rst_rdata", bus.dbg_rdata_o, 32'h0);
    chk("rst_csr_addr", 32'(bus.csr_addr_o), 32'h0);
    chk("rst_csr_wdata", bus.csr_wdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: read, write, set/clear
    txn(12'h300, 2'b00, 32'h0, 1, 1'b0, rd);          chk("mstatus_read", rd, 32'h7);
    txn(12'h341, 2'b01, 32'h1000_0040, 1, 1'b0, rd);  chk("mepc_old", rd, old_mepc);
    txn(12'h341, 2'b00, 32'h0, 1, 1'b0, rd);          chk("mepc_new", rd, 32'h1000_0040);
    txn(12'h7A0, 2'b10, 32'h3, 1, 1'b0, rd);          chk("pcer_set_old", rd, 32'h4);
    txn(12'h7A0, 2'b00, 32'h0, 1, 1'b0, rd);          chk("pcer_after_set", rd, 32'h7);
    txn(12'h7A0, 2'b11, 32'h1, 1, 1'b0, rd);          chk("pcer_clr_old", rd, 32'h7);
    txn(12'h7A0, 2'b00, 32'h0, 1, 1'b0, rd);          chk("pcer_after_clr", rd, 32'h6);

    // Late halt, then back-to-back with request held through the first
    txn(12'h300, 2'b00, 32'h0, 3, 1'b0, rd);
    txn(12'h123, 2'b01, 32'hCAFE_0001, 2, 1'b1, rd);
    txn(12'h123, 2'b00, 32'h0, 1, 1'b0, rd);          chk("b2b_readback", rd, 32'hCAFE_0001);

    // Sticky halt keeps stall high between requests
    bus.dbg_halt_i = 1'b1;
    txn(12'h300, 2'b00, 32'h0, 1, 1'b0, rd);
    bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.dbg_stall_o !== 1'b1) bad++;
    end
    chk("halt_stall_between", 32'(bad), 32'h0);
    txn(12'h7A0, 2'b00, 32'h0, 2, 1'b0, rd);
    bus.dbg_halt_i = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("halt_release_stall", 32'(bus.dbg_stall_o), 32'h0);

    // Timeout boundaries: halt on the last waiting cycle wins; one later is an error
    txn(12'h341, 2'b01, 32'h5555_AAAA, int'(HT), 1'b0, rd);
    txn(12'h341, 2'b01, 32'h1234_5678, int'(HT) + 1, 1'b0, rd);
    txn(12'h341, 2'b00, 32'h0, 1000, 1'b0, rd);
    txn(12'h341, 2'b00, 32'h0, 1, 1'b0, rd);          chk("timeout_no_write", rd, 32'h5555_AAAA);

    // Randomized requests
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 12'h300;
        1:       a = 12'h341;
        2:       a = 12'h7A0;
        default: a = 12'($urandom_range(0, 4095));
      endcase
      txn(a, 2'($urandom_range(0, 3)), $urandom,
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 12)) : int'($urandom_range(1, 5)),
          1'b0, rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during ACCESS: everything drops, no response, no CSR update
    @(negedge clk);
    bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 12'h300; bus.dbg_op_i = 2'b01;
    bus.dbg_wdata_i = 32'hDEAD_BEEF; bus.core_halted_i = 1'b1;
    #1; chk("rst_mid_gnt", 32'(bus.dbg_gnt_o), 32'h1);
    @(negedge clk); bus.dbg_req_i = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_in_access", 32'(bus.csr_access_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.csr_access_o, bus.csr_sel_o, bus.dbg_stall_o,
                            bus.dbg_rvalid_o, bus.dbg_err_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (bus.dbg_rvalid_o !== 1'b0 || bus.csr_access_o !== 1'b0) bad++;
    end
    chk("rst_mid_no_resp", 32'(bad), 32'h0);
    txn(12'h300, 2'b00, 32'h0, 1, 1'b0, rd);          chk("rst_mid_no_write", rd, ref_mem[12'h300]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
